e203_ifu_jalr_rdctrl: RTL and testbench
=======================================

Name: e203_ifu_jalr_rdctrl

Overview:
Sequencer for the IFU JALR-xN target path. It accepts a JALR whose rs1 is a general register, waits for the OITF and IR dependency to clear, and arbitrates the shared regfile rs1 read port against EXU. It then reads xN, forms the target and returns it to the IFU next-PC logic. It replaces the single-cycle rs1 read-set flop with an explicit FSM and adds starvation-bounded arbitration.

Parameters:
PC_SIZE, 32, width of PC and target
XLEN, 32, register/immediate width
RFIDX_W, 5, register index width
STARVE_MAX, 3, consecutive ARB-state losses to EXU before BPU is forced to win (1..15)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
jalr_req  input  1  decoded JALR-xN pending; level, held until tgt_vld
jalr_rs1idx  input  RFIDX_W  rs1 index of the JALR
jalr_imm  input  XLEN  sign-extended JALR offset
oitf_empty  input  1  EXU OITF empty
ir_empty  input  1  IR holds no instruction
ir_valid_clr  input  1  IR being cleared this cycle
ir_rdwen  input  1  IR instruction writes rd
ir_rdidx  input  RFIDX_W  IR instruction rd index
flush  input  1  pipeline flush; aborts request
exu_rd_req  input  1  EXU requests rs1 read port
exu_rd_gnt  output  1  EXU owns rs1 read port this cycle
rf_rs1_ren  output  1  BPU read strobe to regfile rs1 port
rf_rs1_idx  output  RFIDX_W  BPU read index
rf_rs1_rdata  input  XLEN  regfile data, valid the cycle after rf_rs1_ren
bpu_wait  output  1  hold IFU; request in progress
tgt_vld  output  1  one-cycle pulse, tgt_pc valid
tgt_pc  output  PC_SIZE  resolved JALR target

Behaviour:
- Single clock; reset is synchronous and active-high on rst. Reset: state IDLE, starve_cnt 0, idx_q/imm_q/tgt_pc 0. tgt_vld, rf_rs1_ren and bpu_wait are 0. exu_rd_gnt = exu_rd_req.
- FSM states: IDLE, DEP, ARB, RD, RSP. flush has priority over everything: next state IDLE, no capture, tgt_vld and rf_rs1_ren forced 0 in the flush cycle.
- IDLE: if jalr_req & ~flush, latch jalr_rs1idx->idx_q and jalr_imm->imm_q, then go to DEP.
- DEP: dep_clr = oitf_empty & ~(~ir_empty & ~ir_valid_clr & ir_rdwen & (ir_rdidx == idx_q)). If dep_clr, go to ARB; else stay.
- ARB: bpu_win = ~exu_rd_req | (starve_cnt == STARVE_MAX).
  - Win: rf_rs1_ren = 1, rf_rs1_idx = idx_q, starve_cnt cleared, go to RD.
  - Lose: starve_cnt increments, saturating at STARVE_MAX; stay in ARB.
  - Dependency is not re-checked in ARB; EXU issue cannot create a new hazard while IFU is held.
- exu_rd_gnt = exu_rd_req & ~(state==ARB & bpu_win & ~flush). Both grants are never high in the same cycle.
- RD: tgt_pc <= (rf_rs1_rdata[PC_SIZE-1:0] + imm_q[PC_SIZE-1:0]) mod 2^PC_SIZE with bit 0 forced 0. Go to RSP.
- RSP: tgt_vld = 1, bpu_wait = 0. Go to IDLE. Upstream deasserts jalr_req in the cycle after tgt_vld; a high jalr_req then is treated as a new request.
- bpu_wait = (state==IDLE) ? (jalr_req & ~flush) : (state != RSP).
- starve_cnt clears whenever state != ARB.
- rf_rs1_idx = idx_q in all states; it is meaningful only with rf_rs1_ren.
- Latency (no dependency, no contention): request seen in IDLE at cycle 0, DEP c1, ARB/ren c2, RD c3, tgt_vld c4.
- idx_q == 0 is legal: regfile returns 0, so target = imm with bit 0 cleared.
- tgt_pc holds its value after RSP until the next RD capture.

Test Plan:
- Free path: oitf_empty=1, ir_empty=1, exu_rd_req=0; req idx=5, imm=0x10, x5=0x8000_0003 -> ren at c2 with idx 5; tgt_vld at c4 with tgt_pc=0x8000_0012; bpu_wait high c0..c3.
- IR hazard: ir_rdwen=1, ir_rdidx=5 for 3 cycles, then ir_valid_clr=1 -> FSM stays in DEP until the clr cycle, ARB next; no ren during hazard.
- Starvation: exu_rd_req held 1, STARVE_MAX=3 -> exu_rd_gnt high 3 ARB cycles, 4th cycle rf_rs1_ren=1 and exu_rd_gnt=0, then exu_rd_gnt=1 again.
- Flush in RD -> no tgt_vld, state IDLE next cycle, bpu_wait=0. Flush in ARB with win -> rf_rs1_ren=0.
- Wrap/align: x7=0xFFFF_FFFF, imm=0x2 -> tgt_pc=0x0000_0000. idx=0, imm=0xFFFF_FFF1 -> tgt_pc=0xFFFF_FFF0.
- Reset mid-ARB (rst=1 one cycle) -> IDLE, all outputs 0, exu_rd_gnt follows exu_rd_req, starve_cnt 0.

Source files
------------

// File: rtl/e203_ifu_jalr_rdctrl.sv
// JALR-xN target sequencer: waits out OITF/IR hazards on rs1, arbitrates the
// shared regfile rs1 read port against EXU, then forms and returns the target.
module e203_ifu_jalr_rdctrl #(
  parameter int PC_SIZE    = 32,
  parameter int XLEN       = 32,
  parameter int RFIDX_W    = 5,
  parameter int STARVE_MAX = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               jalr_req,
  input  logic [RFIDX_W-1:0] jalr_rs1idx,
  input  logic [XLEN-1:0]    jalr_imm,
  input  logic               oitf_empty,
  input  logic               ir_empty,
  input  logic               ir_valid_clr,
  input  logic               ir_rdwen,
  input  logic [RFIDX_W-1:0] ir_rdidx,
  input  logic               flush,
  input  logic               exu_rd_req,
  output logic               exu_rd_gnt,
  output logic               rf_rs1_ren,
  output logic [RFIDX_W-1:0] rf_rs1_idx,
  input  logic [XLEN-1:0]    rf_rs1_rdata,
  output logic               bpu_wait,
  output logic               tgt_vld,
  output logic [PC_SIZE-1:0] tgt_pc
);

  typedef enum logic [2:0] {IDLE, DEP, ARB, RD, RSP} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t             state_reg, state_next;
  logic [3:0]         starve_cnt_reg, starve_cnt_next;
  logic [RFIDX_W-1:0] idx_reg, idx_next;
  logic [XLEN-1:0]    imm_reg, imm_next;
  logic [PC_SIZE-1:0] tgt_pc_reg, tgt_pc_next;
  logic [PC_SIZE-1:0] tgt_sum;
  logic               dep_clr;
  logic               bpu_win;
  logic               arb_win;

  // rs1 is still in flight if OITF is busy or the IR instruction (not being
  // retired this cycle) is about to write the same register.
  assign dep_clr = oitf_empty &
                   ~(~ir_empty & ~ir_valid_clr & ir_rdwen & (ir_rdidx == idx_reg));
  assign bpu_win = ~exu_rd_req | (starve_cnt_reg == STARVE_LIM);
  assign arb_win = (state_reg == ARB) & bpu_win & ~flush;
  assign tgt_sum = rf_rs1_rdata[PC_SIZE-1:0] + imm_reg[PC_SIZE-1:0];

  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = '0;
    idx_next        = idx_reg;
    imm_next        = imm_reg;
    tgt_pc_next     = tgt_pc_reg;
    rf_rs1_ren      = 1'b0;
    tgt_vld         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (jalr_req) begin
          idx_next   = jalr_rs1idx;
          imm_next   = jalr_imm;
          state_next = DEP;
        end
      end
      DEP: begin
        if (dep_clr) state_next = ARB;
      end
      ARB: begin
        if (bpu_win) begin
          rf_rs1_ren = 1'b1;
          state_next = RD;
        end else begin
          starve_cnt_next = (starve_cnt_reg == STARVE_LIM) ? starve_cnt_reg
                                                           : starve_cnt_reg + 4'd1;
        end
      end
      RD: begin
        tgt_pc_next = {tgt_sum[PC_SIZE-1:1], 1'b0};
        state_next  = RSP;
      end
      RSP: begin
        tgt_vld    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Flush aborts the request outright, whatever stage it has reached.
    if (flush) begin
      state_next      = IDLE;
      starve_cnt_next = '0;
      idx_next        = idx_reg;
      imm_next        = imm_reg;
      tgt_pc_next     = tgt_pc_reg;
      rf_rs1_ren      = 1'b0;
      tgt_vld         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
      idx_reg        <= '0;
      imm_reg        <= '0;
      tgt_pc_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      idx_reg        <= idx_next;
      imm_reg        <= imm_next;
      tgt_pc_reg     <= tgt_pc_next;
    end
  end

  assign exu_rd_gnt = exu_rd_req & ~arb_win;
  assign rf_rs1_idx = idx_reg;
  assign tgt_pc     = tgt_pc_reg;
  assign bpu_wait   = (state_reg == IDLE) ? (jalr_req & ~flush) : (state_reg != RSP);

endmodule

// File: tb/tb_e203_ifu_jalr_rdctrl.sv
// Directed bench for e203_ifu_jalr_rdctrl: free path, hazards, starvation,
// flush, target wrap/alignment and mid-arbitration reset.
module tb_e203_ifu_jalr_rdctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        jalr_req;
  logic [4:0]  jalr_rs1idx;
  logic [31:0] jalr_imm;
  logic        oitf_empty;
  logic        ir_empty;
  logic        ir_valid_clr;
  logic        ir_rdwen;
  logic [4:0]  ir_rdidx;
  logic        flush;
  logic        exu_rd_req;
  logic        exu_rd_gnt;
  logic        rf_rs1_ren;
  logic [4:0]  rf_rs1_idx;
  logic [31:0] rf_rs1_rdata;
  logic        bpu_wait;
  logic        tgt_vld;
  logic [31:0] tgt_pc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  e203_ifu_jalr_rdctrl #(
    .PC_SIZE(32), .XLEN(32), .RFIDX_W(5), .STARVE_MAX(3)
  ) dut (
    .clk(clk), .rst(rst),
    .jalr_req(jalr_req), .jalr_rs1idx(jalr_rs1idx), .jalr_imm(jalr_imm),
    .oitf_empty(oitf_empty), .ir_empty(ir_empty), .ir_valid_clr(ir_valid_clr),
    .ir_rdwen(ir_rdwen), .ir_rdidx(ir_rdidx), .flush(flush),
    .exu_rd_req(exu_rd_req), .exu_rd_gnt(exu_rd_gnt),
    .rf_rs1_ren(rf_rs1_ren), .rf_rs1_idx(rf_rs1_idx), .rf_rs1_rdata(rf_rs1_rdata),
    .bpu_wait(bpu_wait), .tgt_vld(tgt_vld), .tgt_pc(tgt_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Inputs are driven 1 time unit after the edge, outputs checked 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic free_inputs();
    jalr_req = 0; jalr_rs1idx = 0; jalr_imm = 0;
    oitf_empty = 1; ir_empty = 1; ir_valid_clr = 0; ir_rdwen = 0; ir_rdidx = 0;
    flush = 0; exu_rd_req = 0; rf_rs1_rdata = 0;
  endtask

  // Uncontended request; call right after tick() with the DUT idle.
  task automatic run_free(input string tag, input logic [4:0] idx, input logic [31:0] imm,
                          input logic [31:0] rdata, input logic [31:0] exp_tgt);
    jalr_req = 1; jalr_rs1idx = idx; jalr_imm = imm; exu_rd_req = 0;
    #1;
    check({tag, ".c0_wait"}, bpu_wait, 1);
    check({tag, ".c0_ren"}, rf_rs1_ren, 0);
    tick();
    jalr_rs1idx = ~idx; jalr_imm = 32'hDEAD_BEEF;
    #1;
    check({tag, ".c1_wait"}, bpu_wait, 1);
    check({tag, ".c1_ren"}, rf_rs1_ren, 0);
    tick(); #1;
    check({tag, ".c2_ren"}, rf_rs1_ren, 1);
    check({tag, ".c2_idx"}, rf_rs1_idx, idx);
    check({tag, ".c2_wait"}, bpu_wait, 1);
    tick();
    rf_rs1_rdata = rdata;
    #1;
    check({tag, ".c3_ren"}, rf_rs1_ren, 0);
    check({tag, ".c3_wait"}, bpu_wait, 1);
    check({tag, ".c3_vld"}, tgt_vld, 0);
    tick();
    rf_rs1_rdata = 32'h1234_5679;
    #1;
    check({tag, ".c4_vld"}, tgt_vld, 1);
    check({tag, ".c4_pc"}, tgt_pc, exp_tgt);
    check({tag, ".c4_wait"}, bpu_wait, 0);
    tick();
    jalr_req = 0;
    #1;
    check({tag, ".c5_vld"}, tgt_vld, 0);
    check({tag, ".c5_wait"}, bpu_wait, 0);
    check({tag, ".c5_pc_hold"}, tgt_pc, exp_tgt);
  endtask

  initial begin
    int losses;
    free_inputs();
    rst = 1; exu_rd_req = 1;
    tick(); tick();
    #1;
    check("rst.wait", bpu_wait, 0);
    check("rst.vld", tgt_vld, 0);
    check("rst.ren", rf_rs1_ren, 0);
    check("rst.pc", tgt_pc, 0);
    check("rst.gnt_hi", exu_rd_gnt, 1);
    exu_rd_req = 0;
    #1;
    check("rst.gnt_lo", exu_rd_gnt, 0);
    tick();
    rst = 0;
    tick();

    // Free path: x5 = 0x8000_0003, imm 0x10 -> 0x8000_0012
    run_free("free", 5'd5, 32'h10, 32'h8000_0003, 32'h8000_0012);

    // OITF busy then IR hazard on x5, cleared by ir_valid_clr
    tick();
    jalr_req = 1; jalr_rs1idx = 5; jalr_imm = 32'h20;
    oitf_empty = 0;
    tick(); #1;
    check("oitf.dep_ren", rf_rs1_ren, 0);
    oitf_empty = 1; ir_empty = 0; ir_rdwen = 1; ir_rdidx = 5;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      check($sformatf("haz.dep%0d_ren", i), rf_rs1_ren, 0);
      check($sformatf("haz.dep%0d_wait", i), bpu_wait, 1);
    end
    ir_valid_clr = 1;
    tick();
    ir_valid_clr = 0; ir_empty = 1; ir_rdwen = 0;
    #1;
    check("haz.arb_ren", rf_rs1_ren, 1);
    check("haz.arb_idx", rf_rs1_idx, 5);
    tick();
    rf_rs1_rdata = 32'h0000_1000;
    tick(); #1;
    check("haz.vld", tgt_vld, 1);
    check("haz.pc", tgt_pc, 32'h0000_1020);
    tick();
    jalr_req = 0;

    // Starvation: EXU keeps requesting; BPU forced to win on the 4th ARB cycle
    tick();
    jalr_req = 1; jalr_rs1idx = 3; jalr_imm = 32'h4; exu_rd_req = 1;
    #1;
    check("starve.c0_gnt", exu_rd_gnt, 1);
    tick(); #1;
    check("starve.dep_gnt", exu_rd_gnt, 1);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      check($sformatf("starve.arb%0d_gnt", i), exu_rd_gnt, 1);
      check($sformatf("starve.arb%0d_ren", i), rf_rs1_ren, 0);
    end
    tick(); #1;
    check("starve.win_ren", rf_rs1_ren, 1);
    check("starve.win_gnt", exu_rd_gnt, 0);
    tick();
    rf_rs1_rdata = 32'h100;
    #1;
    check("starve.rd_gnt", exu_rd_gnt, 1);
    tick(); #1;
    check("starve.vld", tgt_vld, 1);
    check("starve.pc", tgt_pc, 32'h104);
    tick();
    jalr_req = 0; exu_rd_req = 0;

    // Flush in RD
    tick();
    jalr_req = 1; jalr_rs1idx = 1; jalr_imm = 0;
    tick(); tick(); tick();
    flush = 1; jalr_req = 0; rf_rs1_rdata = 32'h4444_0000;
    #1;
    check("flush_rd.vld", tgt_vld, 0);
    check("flush_rd.ren", rf_rs1_ren, 0);
    tick();
    flush = 0;
    #1;
    check("flush_rd.next_wait", bpu_wait, 0);
    check("flush_rd.next_vld", tgt_vld, 0);
    tick(); #1;
    check("flush_rd.later_vld", tgt_vld, 0);

    // Flush in ARB while BPU would win
    jalr_req = 1; jalr_rs1idx = 2; jalr_imm = 0;
    tick(); tick();
    flush = 1; jalr_req = 0;
    #1;
    check("flush_arb.ren", rf_rs1_ren, 0);
    check("flush_arb.vld", tgt_vld, 0);
    tick();
    flush = 0;
    #1;
    check("flush_arb.next_wait", bpu_wait, 0);
    check("flush_arb.next_ren", rf_rs1_ren, 0);
    tick();

    // Wrap and alignment
    run_free("wrap", 5'd7, 32'h2, 32'hFFFF_FFFF, 32'h0000_0000);
    tick();
    run_free("x0", 5'd0, 32'hFFFF_FFF1, 32'h0, 32'hFFFF_FFF0);

    // Reset while losing in ARB
    tick();
    jalr_req = 1; jalr_rs1idx = 9; jalr_imm = 32'h8; exu_rd_req = 1;
    tick(); tick(); tick();
    rst = 1;
    tick();
    rst = 0; jalr_req = 0;
    #1;
    check("rst_arb.wait", bpu_wait, 0);
    check("rst_arb.vld", tgt_vld, 0);
    check("rst_arb.ren", rf_rs1_ren, 0);
    check("rst_arb.pc", tgt_pc, 0);
    check("rst_arb.gnt", exu_rd_gnt, 1);
    tick();
    jalr_req = 1; jalr_rs1idx = 9; jalr_imm = 32'h8;
    tick();
    losses = 0;
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      if (rf_rs1_ren) break;
      losses++;
    end
    check("rst_arb.losses", losses, 3);
    tick();
    rf_rs1_rdata = 32'h10;
    tick(); #1;
    check("rst_arb.pc_after", tgt_pc, 32'h18);
    tick();
    jalr_req = 0; exu_rd_req = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
